// File: rtl/tqvp_cordic_initiator_pkg.sv
// Shared constants for the TinyQV CORDIC bus initiator: register map, encodings
// and the sequencer state type.
package tqvp_cordic_initiator_pkg;

    localparam logic [5:0] ADDR_CTRL   = 6'd0;
    localparam logic [5:0] ADDR_A      = 6'd1;
    localparam logic [5:0] ADDR_B      = 6'd2;
    localparam logic [5:0] ADDR_SHIFT  = 6'd3;
    localparam logic [5:0] ADDR_OUT1   = 6'd4;
    localparam logic [5:0] ADDR_OUT2   = 6'd5;
    localparam logic [5:0] ADDR_STATUS = 6'd6;

    localparam logic [1:0] MODE_CIRCULAR   = 2'd0;
    localparam logic [1:0] MODE_LINEAR     = 2'd1;
    localparam logic [1:0] MODE_HYPERBOLIC = 2'd2;

    localparam logic [1:0] STATUS_READY = 2'd0;
    localparam logic [1:0] STATUS_BUSY  = 2'd1;
    localparam logic [1:0] STATUS_DONE  = 2'd2;

    localparam logic [1:0] WRITE_8    = 2'b00;
    localparam logic [1:0] WRITE_16   = 2'b01;
    localparam logic [1:0] WRITE_32   = 2'b10;
    localparam logic [1:0] WRITE_IDLE = 2'b11;
    localparam logic [1:0] READ_32    = 2'b10;
    localparam logic [1:0] READ_IDLE  = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_A,
        ST_WR_B,
        ST_WR_SH,
        ST_WR_CTRL,
        ST_WAIT,
        ST_RD1,
        ST_RD2,
        ST_RESP
    } state_t;

endpackage

// File: rtl/tqvp_cordic_initiator.sv
// Host-side sequencer that runs one CORDIC job over the TinyQV peripheral bus:
// operand writes, start, completion wait (irq or status poll), result readback.
//
// state   | meaning
// IDLE    | job_ready high, waiting for a job
// WR_A    | 16-bit write of operand A
// WR_B    | 16-bit write of operand B
// WR_SH   | 8-bit write of the fixed-point shift
// WR_CTRL | 8-bit control write that starts the peripheral
// WAIT    | polling status each cycle, also watching the interrupt
// RD1     | reading out1, held until data_ready
// RD2     | reading out2, held until data_ready
// RESP    | result presented until res_ready
module tqvp_cordic_initiator
    import tqvp_cordic_initiator_pkg::*;
#(
    parameter int FIXED_WIDTH    = 16,
    parameter int SHIFT_W        = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [FIXED_WIDTH-1:0] job_a,
    input  logic [FIXED_WIDTH-1:0] job_b,
    input  logic [1:0]             job_mode,
    input  logic                   job_rotating,
    input  logic [SHIFT_W-1:0]     job_shift,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [FIXED_WIDTH-1:0] res_out1,
    output logic [FIXED_WIDTH-1:0] res_out2,
    output logic                   res_timeout,
    output logic [5:0]             address,
    output logic [31:0]            data_in,
    output logic [1:0]             data_write_n,
    output logic [1:0]             data_read_n,
    input  logic [31:0]            data_out,
    input  logic                   data_ready,
    input  logic                   user_interrupt
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    if (FIXED_WIDTH > 16) begin : g_width_check
        $error("FIXED_WIDTH must not exceed the 16-bit peripheral data path");
    end

    state_t                 state;
    logic [FIXED_WIDTH-1:0] b_q;
    logic [SHIFT_W-1:0]     shift_q;
    logic [1:0]             mode_q;
    logic                   rot_q;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   done_seen;
    logic                   unused_data_hi;

    assign cnt_inc        = cnt + 1'b1;
    // Interrupt and a DONE status read are equivalent completion evidence.
    assign done_seen      = user_interrupt || (data_ready && (data_out[1:0] == STATUS_DONE));
    assign unused_data_hi = ^data_out[31:FIXED_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            job_ready    <= 1'b1;
            res_valid    <= 1'b0;
            res_timeout  <= 1'b0;
            res_out1     <= '0;
            res_out2     <= '0;
            address      <= '0;
            data_in      <= '0;
            data_write_n <= WRITE_IDLE;
            data_read_n  <= READ_IDLE;
            cnt          <= '0;
            b_q          <= '0;
            shift_q      <= '0;
            mode_q       <= '0;
            rot_q        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (job_valid) begin
                        b_q          <= job_b;
                        shift_q      <= job_shift;
                        mode_q       <= job_mode;
                        rot_q        <= job_rotating;
                        job_ready    <= 1'b0;
                        address      <= ADDR_A;
                        data_in      <= 32'(job_a);
                        data_write_n <= WRITE_16;
                        state        <= ST_WR_A;
                    end
                end
                ST_WR_A: begin
                    address <= ADDR_B;
                    data_in <= 32'(b_q);
                    state   <= ST_WR_B;
                end
                ST_WR_B: begin
                    address      <= ADDR_SHIFT;
                    data_in      <= 32'(shift_q);
                    data_write_n <= WRITE_8;
                    state        <= ST_WR_SH;
                end
                ST_WR_SH: begin
                    address <= ADDR_CTRL;
                    data_in <= 32'({rot_q, mode_q, 1'b1});
                    state   <= ST_WR_CTRL;
                end
                ST_WR_CTRL: begin
                    address      <= ADDR_STATUS;
                    data_in      <= '0;
                    data_write_n <= WRITE_IDLE;
                    data_read_n  <= READ_32;
                    cnt          <= '0;
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt_inc;
                    if (done_seen) begin
                        address <= ADDR_OUT1;
                        state   <= ST_RD1;
                    end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                        address     <= '0;
                        data_read_n <= READ_IDLE;
                        res_out1    <= '0;
                        res_out2    <= '0;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RD1: begin
                    if (data_ready) begin
                        res_out1 <= data_out[FIXED_WIDTH-1:0];
                        address  <= ADDR_OUT2;
                        state    <= ST_RD2;
                    end
                end
                ST_RD2: begin
                    if (data_ready) begin
                        res_out2    <= data_out[FIXED_WIDTH-1:0];
                        address     <= '0;
                        data_read_n <= READ_IDLE;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        res_timeout <= 1'b0;
                        job_ready   <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    job_ready    <= 1'b1;
                    res_valid    <= 1'b0;
                    res_timeout  <= 1'b0;
                    address      <= '0;
                    data_in      <= '0;
                    data_write_n <= WRITE_IDLE;
                    data_read_n  <= READ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tqvp_cordic_initiator.md
Name: tqvp_cordic_initiator

Overview:
- Bus initiator (host end) for the TinyQV peripheral register interface, dedicated to driving the CORDIC peripheral.
- Accepts a job (A, B, mode, rotate flag, shift) on a valid/ready port and sequences the peripheral writes (A, B, shift, control/start).
- Waits for completion by interrupt, with status-register polling as a fallback, then reads out1/out2 and returns them on a valid/ready result port.
- Lets hardware test harnesses and accelerator chains use the CORDIC without the CPU.

Parameters:
FIXED_WIDTH, 16, operand/result width; must be <= 16 (peripheral data path is 16-bit)
SHIFT_W, 5, width of shift field (clog2(FIXED_WIDTH)+1)
TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before aborting the job

Ports:
clk  in  1  project clock
rst_n  in  1  asynchronous active-low reset
job_valid  in  1  job offered
job_ready  out  1  job accepted when job_valid & job_ready
job_a  in  FIXED_WIDTH  operand A
job_b  in  FIXED_WIDTH  operand B
job_mode  in  2  0 circular, 1 linear, 2 hyperbolic
job_rotating  in  1  rotation (1) / vectoring (0)
job_shift  in  SHIFT_W  fixed-point position of 1.0
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid & res_ready
res_out1  out  FIXED_WIDTH  peripheral out1
res_out2  out  FIXED_WIDTH  peripheral out2
res_timeout  out  1  job aborted by timeout; res_out1/res_out2 are 0
address  out  6  peripheral register address
data_in  out  32  write data to peripheral
data_write_n  out  2  11 idle, 00 8-bit, 01 16-bit, 10 32-bit
data_read_n  out  2  11 idle, 10 32-bit read
data_out  in  32  read data from peripheral
data_ready  in  1  read data valid
user_interrupt  in  1  1-cycle done pulse from peripheral

Behaviour:
- Reset (async, immediate): state IDLE.
  - Outputs: job_ready=1, res_valid=0, res_timeout=0, res_out1/2=0, address=0, data_in=0, data_write_n=11, data_read_n=11.
  - Timeout counter=0.
  - Reset mid-job abandons the job; no bus cycle is completed or replayed.
- All outputs are registered. The bus is idle (write_n=11, read_n=11) in every state not listed below as driving it.
- States and actions:
  - IDLE: job_ready=1. On handshake, latch the job fields and go to WR_A.
  - WR_A: address=1, data_in={16'b0,A}, write_n=01. Exactly one cycle, then WR_B.
  - WR_B: address=2, data_in=B, write_n=01. One cycle, then WR_SH.
  - WR_SH: address=3, data_in=shift zero-extended, write_n=00. One cycle, then WR_CTRL.
  - WR_CTRL: address=0, data_in={28'b0,rotating,mode,1'b1}, write_n=00. One cycle, then WAIT; clear the timeout counter.
  - WAIT: address=6, read_n=10 every cycle; the counter increments each cycle.
    - Exit to RD1 when user_interrupt=1, or when data_ready=1 and data_out[1:0]==2.
    - Otherwise, when the counter reaches TIMEOUT_CYCLES, go to RESP with res_timeout=1 and results 0.
    - If completion and timeout occur in the same cycle, completion wins.
  - RD1: address=4, read_n=10. Hold until data_ready=1, capture data_out[FIXED_WIDTH-1:0] into res_out1, then RD2.
  - RD2: address=5. Same as RD1, capturing into res_out2, then RESP.
  - RESP: res_valid=1. Outputs are held stable until res_ready=1, then clear res_valid and res_timeout and go to IDLE.
- job_ready=0 in every state except IDLE; no job queueing.
- user_interrupt outside WAIT is ignored.
- Latency with data_ready tied 1 and the interrupt arriving N cycles after WR_CTRL:
  - res_valid rises 4+N+2+1 cycles after the job handshake.
  - Back-to-back jobs: next job_ready one cycle after the RESP handshake.
- The write sequence never reorders; control is always the last write, so start always sees fresh operands.

Decomposition:
- Shared package:
  - Register address constants: CTRL=0, A=1, B=2, SHIFT=3, OUT1=4, OUT2=5, STATUS=6.
  - Mode encodings, status encodings (READY=0, BUSY=1, DONE=2), write/read size encodings.
  - State enum.
- No sub-module. A single FSM plus counter and latches; the optional bus-driver mux stays inline.

Test Plan:
- Circular rotation: A=0x026E (K=0.607 at shift 10), B=0, mode 0, rotating 1, shift 10, paired with the real peripheral -> writes on addr 1,2,3,0 in consecutive cycles, ctrl data 0x9; res_out1 ~ 0x0400, res_out2 ~ 0; res_timeout=0.
- Bus model with interrupt never asserted, status reads 1 then 2 after 20 cycles -> exits WAIT via poll, reads addr 4 then 5, res_valid once.
- Status stuck at 1, no interrupt -> res_valid after exactly TIMEOUT_CYCLES in WAIT, res_timeout=1, outputs 0; next job accepted normally.
- data_ready low 3 cycles during RD1 -> address=4/read_n=10 held, data captured only on the data_ready cycle.
- res_ready held low 10 cycles, job_valid high throughout -> outputs stable, job_ready=0; handshake then IDLE, second job starts the next cycle.
- rst_n asserted during WR_B and during WAIT -> bus outputs idle immediately (async), job_ready=1, res_valid=0; a fresh job then completes correctly.
